xs_sdr_rom_arbiter: RTL and testbench
=====================================

// Module: xs_sdr_rom_arbiter
// PURPOSE
// Responder side of the per-layer SDRAM ROM request interface (sdr_addr/sdr_req/sdr_rdy/sdr_data).
// Collects one-cycle read requests from NCH video/CPU ROM clients (BACK1, BACK2, FRONT, OBJ, ...).
// Serialises them round-robin onto a single downstream SDRAM controller read port.
// Returns each 16-bit word to the originating client with a one-cycle sdr_rdy pulse.
// PARAMETERS
// NCH      4    number of client channels (2..8)
// AW       25   SDRAM word address width
// TIMEOUT  63   max cycles waiting for mem_ack before forced completion (6-bit counter)
// PORTS
// clk_ram    in   1        SDRAM-domain clock; all logic on posedge
// RESET      in   1        asynchronous, active-high reset
// sdr_req    in   NCH      per-client request pulse, 1 cycle, bit i = client i
// sdr_addr   in   NCH*AW   per-client address, slice i valid in the cycle sdr_req[i]=1
// sdr_rdy    out  NCH      per-client completion pulse, 1 cycle
// sdr_data   out  NCH*16   per-client read data, slice i valid from sdr_rdy[i] until next rdy[i]
// mem_addr   out  AW       address to SDRAM controller
// mem_rd     out  1        read strobe to controller, 1-cycle pulse
// mem_ack    in   1        controller completion pulse, mem_dout valid same cycle
// mem_dout   in   16       controller read data
// busy       out  1        1 while a downstream read is outstanding (debug/OSD)
// BEHAVIOUR
// Reset: sdr_rdy=0, sdr_data=all 16'hFFFF, mem_rd=0, mem_addr=0, busy=0; pending flags clear;
//   RR pointer=0; FSM=IDLE; timeout counter=0. Async assert, release synchronised internally.
// Capture: sdr_req[i]=1 sets pend[i] and latches addr_q[i]<=sdr_addr slice i.
//   Request on a channel already pending (not yet issued): addr_q overwritten, latest wins, one service.
//   Request on the channel currently in flight: latched as new pend, served after current completes.
// FSM states IDLE -> ISSUE -> WAIT -> IDLE.
//   IDLE: if any pend, pick first pending channel at or after RR pointer (wrap NCH-1 -> 0);
//     cur<=ch, clear pend[ch] (unless sdr_req[ch] same cycle: re-set with new addr), go ISSUE.
//     Capture and selection in the same cycle: a request arriving this cycle is not yet selectable.
//   ISSUE: mem_addr<=addr_q[cur], mem_rd=1 for exactly this cycle, busy=1, go WAIT.
//   WAIT: on mem_ack: sdr_data[cur]<=mem_dout, sdr_rdy[cur]=1 next cycle, RR ptr<=cur+1 mod NCH, go IDLE.
//     Counter increments each WAIT cycle without ack; reaching TIMEOUT: sdr_data[cur]<=16'hFFFF,
//     sdr_rdy[cur] pulsed, go IDLE. mem_ack outside WAIT is ignored.
// Latency: req at cycle 0 on idle arbiter -> mem_rd at cycle 2 -> rdy at ack cycle+1.
// At most one outstanding downstream read; sdr_rdy is one-hot or zero every cycle.
// Fairness: each pending channel serviced within NCH grants.
// mem_addr holds last issued value between reads; busy deasserts the cycle rdy pulses.
// RESET mid-WAIT: transaction dropped, no rdy pulse; a late mem_ack after release is ignored (FSM in IDLE).
// TESTING
// 1 Single req ch1 addr 25'h0012340, ack after 5 cycles with 16'hA55A -> mem_rd once, mem_addr 0x0012340, rdy[1] once, data[1]=A55A.
// 2 Same-cycle req on ch0..ch3, RR ptr=2 -> service order 2,3,0,1; each rdy exactly once, correct data per channel.
// 3 Two reqs on ch0 (addr 0x100 then 0x200) before issue -> single mem_rd with addr 0x200, one rdy[0].
// 4 Req ch2 during ch2 in flight -> two mem_rd, two rdy[2] pulses in order, second data distinct.
// 5 No mem_ack for 63 WAIT cycles -> rdy pulsed, data=16'hFFFF, FSM IDLE, next pending req issued.
// 6 RESET asserted in WAIT then late mem_ack -> no rdy, outputs at reset values, next req served normally.

Source files
------------

// File: rtl/xs_sdr_rom_arbiter_if.sv
// Client/SDRAM-side bundle of the ROM request arbiter.
// slave = the arbiter itself, master = clients plus controller.
interface xs_sdr_rom_arbiter_if #(
    parameter int NCH = 4,
    parameter int AW  = 25
);
    logic [NCH-1:0]    sdr_req;
    logic [NCH*AW-1:0] sdr_addr;
    logic [NCH-1:0]    sdr_rdy;
    logic [NCH*16-1:0] sdr_data;
    logic [AW-1:0]     mem_addr;
    logic              mem_rd;
    logic              mem_ack;
    logic [15:0]       mem_dout;
    logic              busy;

    modport slave (
        input  sdr_req,
        input  sdr_addr,
        input  mem_ack,
        input  mem_dout,
        output sdr_rdy,
        output sdr_data,
        output mem_addr,
        output mem_rd,
        output busy
    );

    modport master (
        output sdr_req,
        output sdr_addr,
        output mem_ack,
        output mem_dout,
        input  sdr_rdy,
        input  sdr_data,
        input  mem_addr,
        input  mem_rd,
        input  busy
    );
endinterface

// File: rtl/xs_sdr_rom_arbiter.sv
// Round-robin arbiter serialising per-client ROM reads onto one
// SDRAM read port, with per-read timeout and one-cycle rdy return.
module xs_sdr_rom_arbiter #(
    parameter int NCH     = 4,
    parameter int AW      = 25,
    parameter int TIMEOUT = 63
) (
    input  logic                  clk_ram,
    input  logic                  RESET,
    xs_sdr_rom_arbiter_if.slave   bus
);
    localparam int CW = $clog2(NCH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Reset asserts immediately, releases two clock edges later
    logic [1:0] r_rst_sync;
    logic       w_rst;

    always_ff @(posedge clk_ram or posedge RESET) begin
        if (RESET) r_rst_sync <= 2'b11;
        else       r_rst_sync <= {r_rst_sync[0], 1'b0};
    end

    assign w_rst = r_rst_sync[1];

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NCH-1:0]  r_pend;
    logic [AW-1:0]   r_addr_q [NCH];
    logic [CW-1:0]   r_rr;
    logic [CW-1:0]   r_cur;
    logic [5:0]      r_cnt;
    logic [NCH-1:0]  r_rdy;
    logic [15:0]     r_data [NCH];
    logic [AW-1:0]   r_mem_addr;

    logic            w_any;
    logic [CW-1:0]   w_sel;
    int              w_idx;
    logic [NCH-1:0]  w_clr;
    logic            w_grant;
    logic            w_done_ack;
    logic            w_done_to;
    logic [CW-1:0]   w_rr_nxt;
    logic            w_mem_rd;
    logic            w_busy;
    logic [NCH*16-1:0] w_data_flat;

    // Scan downwards so the nearest pending channel at/after r_rr wins
    always_comb begin
        w_any = 1'b0;
        w_sel = r_rr;
        w_idx = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            w_idx = (int'(r_rr) + k) % NCH;
            if (r_pend[w_idx]) begin
                w_any = 1'b1;
                w_sel = CW'(w_idx);
            end
        end
    end

    assign w_grant    = (r_state == S_IDLE) && w_any;
    assign w_done_ack = (r_state == S_WAIT) && bus.mem_ack;
    assign w_done_to  = (r_state == S_WAIT) && !bus.mem_ack
                        && (r_cnt == 6'(TIMEOUT - 1));
    assign w_rr_nxt   = (r_cur == CW'(NCH - 1)) ? '0 : r_cur + 1'b1;

    always_comb begin
        w_clr = '0;
        if (w_grant) w_clr[w_sel] = 1'b1;
    end

    always_ff @(posedge clk_ram or posedge w_rst) begin
        if (w_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (w_done_ack || w_done_to) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_mem_rd = 1'b0;
        w_busy   = 1'b0;
        case (r_state)
            S_ISSUE: begin
                w_mem_rd = 1'b1;
                w_busy   = 1'b1;
            end
            S_WAIT:  w_busy = 1'b1;
            default: ;
        endcase
    end

    // Address is loaded at grant so it is stable during the mem_rd cycle
    always_ff @(posedge clk_ram or posedge w_rst) begin
        if (w_rst) begin
            r_pend     <= '0;
            r_rr       <= '0;
            r_cur      <= '0;
            r_cnt      <= '0;
            r_rdy      <= '0;
            r_mem_addr <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_addr_q[i] <= '0;
                r_data[i]   <= 16'hFFFF;
            end
        end else begin
            r_rdy  <= '0;
            r_pend <= (r_pend & ~w_clr) | bus.sdr_req;
            for (int i = 0; i < NCH; i++) begin
                if (bus.sdr_req[i]) r_addr_q[i] <= bus.sdr_addr[i*AW +: AW];
            end
            if (w_grant) begin
                r_cur      <= w_sel;
                r_mem_addr <= r_addr_q[w_sel];
            end
            if (r_state == S_ISSUE) r_cnt <= '0;
            if (w_done_ack) begin
                r_data[r_cur] <= bus.mem_dout;
                r_rdy[r_cur]  <= 1'b1;
                r_rr          <= w_rr_nxt;
            end else if (w_done_to) begin
                r_data[r_cur] <= 16'hFFFF;
                r_rdy[r_cur]  <= 1'b1;
                r_rr          <= w_rr_nxt;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 6'd1;
            end
        end
    end

    always_comb begin
        w_data_flat = '0;
        for (int i = 0; i < NCH; i++) w_data_flat[i*16 +: 16] = r_data[i];
    end

    assign bus.sdr_rdy  = r_rdy;
    assign bus.sdr_data = w_data_flat;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_rd   = w_mem_rd;
    assign bus.busy     = w_busy;

endmodule

// File: tb/tb_xs_sdr_rom_arbiter.sv
// Directed bench for the SDRAM ROM arbiter: latency, round-robin,
// request merging, re-request in flight, timeout and mid-read reset.
module tb_xs_sdr_rom_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    int n_rd = 0;
    int n_rdy [4] = '{0, 0, 0, 0};
    int n_bad = 0;

    xs_sdr_rom_arbiter_if #(.NCH(4), .AW(25)) bus ();

    xs_sdr_rom_arbiter #(.NCH(4), .AW(25), .TIMEOUT(63)) dut (
        .clk_ram (clk),
        .RESET   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_rd) n_rd++;
            for (int i = 0; i < 4; i++) if (bus.sdr_rdy[i]) n_rdy[i]++;
            if (!$onehot0(bus.sdr_rdy)) n_bad++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int ch, input logic [24:0] a);
        bus.sdr_req = '0;
        bus.sdr_req[ch] = 1'b1;
        bus.sdr_addr[ch*25 +: 25] = a;
        tick();
        bus.sdr_req = '0;
    endtask

    task automatic wait_rd(output bit ok, output logic [24:0] a);
        ok = 1'b0;
        a = '0;
        for (int i = 0; i < 40; i++) begin
            if (bus.mem_rd) begin
                ok = 1'b1;
                a = bus.mem_addr;
                break;
            end
            tick();
        end
    endtask

    task automatic ack_after(input int dly, input logic [15:0] d);
        tick();
        repeat (dly) tick();
        bus.mem_ack = 1'b1;
        bus.mem_dout = d;
        tick();
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_reset;
        tick();
        tick();
        n_checks++;
        if (bus.sdr_rdy !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_rdy got %b exp 0000", bus.sdr_rdy);
        end
        n_checks++;
        if (bus.sdr_data !== {4{16'hFFFF}}) begin
            n_fail++;
            $display("FAIL rst_data got %h exp all FFFF", bus.sdr_data);
        end
        n_checks++;
        if (bus.mem_rd !== 1'b0 || bus.busy !== 1'b0 || bus.mem_addr !== 25'h0) begin
            n_fail++;
            $display("FAIL rst_mem got rd=%b busy=%b addr=%h exp 0/0/0",
                     bus.mem_rd, bus.busy, bus.mem_addr);
        end
        rst = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_single;
        int b_rd = n_rd;
        int b_r1 = n_rdy[1];
        req(1, 25'h0012340);
        n_checks++;
        if (bus.mem_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_early_rd got %b exp 0", bus.mem_rd);
        end
        tick();
        n_checks++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 25'h0012340) begin
            n_fail++;
            $display("FAIL t1_issue got rd=%b addr=%h exp 1/0012340",
                     bus.mem_rd, bus.mem_addr);
        end
        ack_after(5, 16'hA55A);
        n_checks++;
        if (bus.sdr_rdy !== 4'b0010 || bus.sdr_data[31:16] !== 16'hA55A) begin
            n_fail++;
            $display("FAIL t1_rdy got rdy=%b d=%h exp 0010/A55A",
                     bus.sdr_rdy, bus.sdr_data[31:16]);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_busy got %b exp 0", bus.busy);
        end
        tick();
        tick();
        n_checks++;
        if (n_rd - b_rd !== 1 || n_rdy[1] - b_r1 !== 1) begin
            n_fail++;
            $display("FAIL t1_counts got rd=%0d rdy=%0d exp 1/1",
                     n_rd - b_rd, n_rdy[1] - b_r1);
        end
    endtask

    task automatic test_round_robin;
        bit ok;
        logic [24:0] a;
        int exp_ch;
        bus.sdr_req = 4'hF;
        for (int i = 0; i < 4; i++) bus.sdr_addr[i*25 +: 25] = 25'h20 + 25'(i);
        tick();
        bus.sdr_req = '0;
        for (int k = 0; k < 4; k++) begin
            exp_ch = (2 + k) % 4;
            wait_rd(ok, a);
            n_checks++;
            if (!ok || a !== 25'h20 + 25'(exp_ch)) begin
                n_fail++;
                $display("FAIL t2_order%0d got ok=%b addr=%h exp addr=%h",
                         k, ok, a, 25'h20 + 25'(exp_ch));
            end
            ack_after(1, 16'h1000 + 16'(exp_ch));
            n_checks++;
            if (bus.sdr_rdy !== 4'(1 << exp_ch) ||
                bus.sdr_data[exp_ch*16 +: 16] !== 16'h1000 + 16'(exp_ch)) begin
                n_fail++;
                $display("FAIL t2_rdy%0d got rdy=%b d=%h exp ch%0d d=%h", k,
                         bus.sdr_rdy, bus.sdr_data[exp_ch*16 +: 16], exp_ch,
                         16'h1000 + 16'(exp_ch));
            end
        end
        tick();
    endtask

    task automatic test_merge;
        bit ok;
        logic [24:0] a;
        int b_rd = n_rd;
        int b_r0 = n_rdy[0];
        req(1, 25'h300);
        wait_rd(ok, a);
        tick();
        req(0, 25'h100);
        req(0, 25'h200);
        bus.mem_ack = 1'b1;
        bus.mem_dout = 16'h1111;
        tick();
        bus.mem_ack = 1'b0;
        n_checks++;
        if (!ok || a !== 25'h300 || bus.sdr_rdy !== 4'b0010) begin
            n_fail++;
            $display("FAIL t3_first got ok=%b addr=%h rdy=%b exp 300/0010",
                     ok, a, bus.sdr_rdy);
        end
        wait_rd(ok, a);
        n_checks++;
        if (!ok || a !== 25'h200) begin
            n_fail++;
            $display("FAIL t3_latest got ok=%b addr=%h exp 200", ok, a);
        end
        ack_after(2, 16'hC0DE);
        n_checks++;
        if (bus.sdr_rdy !== 4'b0001 || bus.sdr_data[15:0] !== 16'hC0DE) begin
            n_fail++;
            $display("FAIL t3_rdy got rdy=%b d=%h exp 0001/C0DE",
                     bus.sdr_rdy, bus.sdr_data[15:0]);
        end
        repeat (6) tick();
        n_checks++;
        if (n_rd - b_rd !== 2 || n_rdy[0] - b_r0 !== 1) begin
            n_fail++;
            $display("FAIL t3_counts got rd=%0d rdy0=%0d exp 2/1",
                     n_rd - b_rd, n_rdy[0] - b_r0);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [24:0] a;
        int b_rd = n_rd;
        int b_r2 = n_rdy[2];
        req(2, 25'h2A);
        wait_rd(ok, a);
        n_checks++;
        if (!ok || a !== 25'h2A) begin
            n_fail++;
            $display("FAIL t4_first got ok=%b addr=%h exp 2A", ok, a);
        end
        tick();
        req(2, 25'h2B);
        bus.mem_ack = 1'b1;
        bus.mem_dout = 16'h2222;
        tick();
        bus.mem_ack = 1'b0;
        n_checks++;
        if (bus.sdr_rdy !== 4'b0100 || bus.sdr_data[47:32] !== 16'h2222) begin
            n_fail++;
            $display("FAIL t4_rdy1 got rdy=%b d=%h exp 0100/2222",
                     bus.sdr_rdy, bus.sdr_data[47:32]);
        end
        wait_rd(ok, a);
        n_checks++;
        if (!ok || a !== 25'h2B) begin
            n_fail++;
            $display("FAIL t4_second got ok=%b addr=%h exp 2B", ok, a);
        end
        ack_after(2, 16'h3333);
        n_checks++;
        if (bus.sdr_rdy !== 4'b0100 || bus.sdr_data[47:32] !== 16'h3333) begin
            n_fail++;
            $display("FAIL t4_rdy2 got rdy=%b d=%h exp 0100/3333",
                     bus.sdr_rdy, bus.sdr_data[47:32]);
        end
        repeat (4) tick();
        n_checks++;
        if (n_rd - b_rd !== 2 || n_rdy[2] - b_r2 !== 2) begin
            n_fail++;
            $display("FAIL t4_counts got rd=%0d rdy2=%0d exp 2/2",
                     n_rd - b_rd, n_rdy[2] - b_r2);
        end
    endtask

    task automatic test_timeout;
        bit ok;
        logic [24:0] a;
        req(3, 25'h333);
        wait_rd(ok, a);
        tick();
        req(0, 25'h044);
        repeat (61) tick();
        n_checks++;
        if (bus.busy !== 1'b1 || bus.sdr_rdy !== 4'b0) begin
            n_fail++;
            $display("FAIL t5_early got busy=%b rdy=%b exp 1/0000",
                     bus.busy, bus.sdr_rdy);
        end
        tick();
        n_checks++;
        if (bus.sdr_rdy !== 4'b1000 || bus.sdr_data[63:48] !== 16'hFFFF ||
            bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_expire got rdy=%b d=%h busy=%b exp 1000/FFFF/0",
                     bus.sdr_rdy, bus.sdr_data[63:48], bus.busy);
        end
        wait_rd(ok, a);
        n_checks++;
        if (!ok || a !== 25'h044) begin
            n_fail++;
            $display("FAIL t5_next got ok=%b addr=%h exp 044", ok, a);
        end
        ack_after(0, 16'h0440);
        n_checks++;
        if (bus.sdr_rdy !== 4'b0001 || bus.sdr_data[15:0] !== 16'h0440) begin
            n_fail++;
            $display("FAIL t5_rdy got rdy=%b d=%h exp 0001/0440",
                     bus.sdr_rdy, bus.sdr_data[15:0]);
        end
        tick();
    endtask

    task automatic test_reset_in_wait;
        bit ok;
        logic [24:0] a;
        int b_r1;
        req(1, 25'h111);
        wait_rd(ok, a);
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.sdr_rdy !== 4'b0 || bus.busy !== 1'b0 || bus.mem_rd !== 1'b0 ||
            bus.mem_addr !== 25'h0 || bus.sdr_data !== {4{16'hFFFF}}) begin
            n_fail++;
            $display("FAIL t6_reset got rdy=%b busy=%b addr=%h d=%h exp reset values",
                     bus.sdr_rdy, bus.busy, bus.mem_addr, bus.sdr_data);
        end
        tick();
        rst = 1'b0;
        repeat (3) tick();
        b_r1 = n_rdy[1];
        bus.mem_ack = 1'b1;
        bus.mem_dout = 16'hBEEF;
        tick();
        bus.mem_ack = 1'b0;
        tick();
        n_checks++;
        if (n_rdy[1] - b_r1 !== 0 || bus.busy !== 1'b0 ||
            bus.sdr_data[31:16] !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL t6_late_ack got rdy1=%0d busy=%b d=%h exp 0/0/FFFF",
                     n_rdy[1] - b_r1, bus.busy, bus.sdr_data[31:16]);
        end
        req(2, 25'h222);
        wait_rd(ok, a);
        n_checks++;
        if (!ok || a !== 25'h222) begin
            n_fail++;
            $display("FAIL t6_after got ok=%b addr=%h exp 222", ok, a);
        end
        ack_after(3, 16'h5A5A);
        n_checks++;
        if (bus.sdr_rdy !== 4'b0100 || bus.sdr_data[47:32] !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL t6_rdy got rdy=%b d=%h exp 0100/5A5A",
                     bus.sdr_rdy, bus.sdr_data[47:32]);
        end
        tick();
    endtask

    task automatic test_onehot;
        n_checks++;
        if (n_bad !== 0) begin
            n_fail++;
            $display("FAIL rdy_onehot got %0d bad cycles exp 0", n_bad);
        end
    endtask

    initial begin
        bus.sdr_req  = '0;
        bus.sdr_addr = '0;
        bus.mem_ack  = 1'b0;
        bus.mem_dout = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_merge();
        test_back_to_back();
        test_timeout();
        test_reset_in_wait();
        test_onehot();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
